// File: rtl/img_mem_arbiter.sv
// img_mem_arbiter
//   Owns the single-port image RAM. Arbitrates the host command path, the zoom
//   engine and the VGA prefetch. It issues at most one access per clock and
//   returns read data with a valid strobe for each requester. The zoom engine
//   can take an exclusive lock that shuts the host out for whole-frame passes.
//
// Ports
//   i_clk, i_rst                    clock, synchronous active-high reset
//   i_host_req/we/addr/wdata        host request (held until o_host_gnt)
//   o_host_gnt, o_host_rvalid       host grant (combinational), read strobe
//   i_zoom_req/we/addr/wdata        zoom engine request
//   o_zoom_gnt, o_zoom_rvalid       zoom grant, read strobe
//   i_zoom_lock_req, o_zoom_lock_ack  exclusive-access handshake
//   i_vga_req, i_vga_addr           VGA prefetch read request
//   o_vga_gnt, o_vga_rvalid         VGA grant, read strobe
//   o_rd_data                       shared read data, qualified by *_rvalid
//   o_mem_addr/wdata/wren           registered RAM controls
//   i_mem_q                         RAM read data (READ_LATENCY after o_mem_*)
module img_mem_arbiter #(
    parameter int ADDR_W       = 16,
    parameter int DATA_W       = 16,
    parameter int MEM_DEPTH    = 19200,
    parameter int READ_LATENCY = 2
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_host_req,
    input  logic              i_host_we,
    input  logic [ADDR_W-1:0] i_host_addr,
    input  logic [DATA_W-1:0] i_host_wdata,
    output logic              o_host_gnt,
    output logic              o_host_rvalid,
    input  logic              i_zoom_req,
    input  logic              i_zoom_we,
    input  logic [ADDR_W-1:0] i_zoom_addr,
    input  logic [DATA_W-1:0] i_zoom_wdata,
    output logic              o_zoom_gnt,
    output logic              o_zoom_rvalid,
    input  logic              i_zoom_lock_req,
    output logic              o_zoom_lock_ack,
    input  logic              i_vga_req,
    input  logic [ADDR_W-1:0] i_vga_addr,
    output logic              o_vga_gnt,
    output logic              o_vga_rvalid,
    output logic [DATA_W-1:0] o_rd_data,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [DATA_W-1:0] o_mem_wdata,
    output logic              o_mem_wren,
    input  logic [DATA_W-1:0] i_mem_q
);

    localparam int PIPE_D = READ_LATENCY + 1;
    // One extra bit so a depth equal to 2**ADDR_W still compares correctly.
    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(MEM_DEPTH);

    localparam logic [1:0] ID_HOST = 2'd0;
    localparam logic [1:0] ID_ZOOM = 2'd1;
    localparam logic [1:0] ID_VGA  = 2'd2;

    typedef enum logic [1:0] {ST_ARB, ST_FLUSH, ST_LOCK} state_t;

    state_t                   r_state;
    logic                     r_lock_ack;
    logic                     r_rr_host;   // 1: host wins a host/zoom tie
    logic [ADDR_W-1:0]        r_mem_addr;
    logic [DATA_W-1:0]        r_mem_wdata;
    logic                     r_mem_wren;

    // Read pipeline: valid, requester id and out-of-range flag per stage.
    logic [PIPE_D-1:0]        r_pv;
    logic [PIPE_D-1:0][1:0]   r_pid;
    logic [PIPE_D-1:0]        r_poor;

    logic                     w_host_cand;
    logic                     w_zoom_cand;
    logic                     w_vga_win;
    logic                     w_host_win;
    logic                     w_zoom_win;
    logic                     w_any;
    logic [ADDR_W-1:0]        w_sel_addr;
    logic [DATA_W-1:0]        w_sel_wdata;
    logic                     w_sel_we;
    logic [1:0]               w_sel_id;
    logic                     w_oor;
    logic                     w_host_rd_inflight;

    // Grant selection. Grants are suppressed during reset. VGA is strict
    // highest priority; host is only eligible while arbitrating normally.
    assign w_vga_win   = i_vga_req & ~i_rst;
    assign w_host_cand = i_host_req & (r_state == ST_ARB) & ~i_rst & ~i_vga_req;
    assign w_zoom_cand = i_zoom_req & ~i_rst & ~i_vga_req;
    assign w_host_win  = w_host_cand & (~w_zoom_cand | r_rr_host);
    assign w_zoom_win  = w_zoom_cand & (~w_host_cand | ~r_rr_host);
    assign w_any       = w_vga_win | w_host_win | w_zoom_win;

    always_comb begin
        w_sel_addr  = i_vga_addr;
        w_sel_wdata = '0;
        w_sel_we    = 1'b0;
        w_sel_id    = ID_VGA;
        if (w_host_win) begin
            w_sel_addr  = i_host_addr;
            w_sel_wdata = i_host_wdata;
            w_sel_we    = i_host_we;
            w_sel_id    = ID_HOST;
        end else if (w_zoom_win) begin
            w_sel_addr  = i_zoom_addr;
            w_sel_wdata = i_zoom_wdata;
            w_sel_we    = i_zoom_we;
            w_sel_id    = ID_ZOOM;
        end
    end

    assign w_oor = ({1'b0, w_sel_addr} >= DEPTH_C);

    // The lock may only be taken once no host read is still travelling
    // through the pipeline, so the host never loses a result.
    always_comb begin
        w_host_rd_inflight = 1'b0;
        for (int i = 0; i < PIPE_D; i++) begin
            if (r_pv[i] && (r_pid[i] == ID_HOST)) w_host_rd_inflight = 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= ST_ARB;
            r_lock_ack  <= 1'b0;
            r_rr_host   <= 1'b1;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_mem_wren  <= 1'b0;
            r_pv        <= '0;
            r_pid       <= '0;
            r_poor      <= '0;
        end else begin
            // Memory port: idle cycles hold the address and drop wren.
            if (w_any) begin
                r_mem_addr  <= w_sel_addr;
                r_mem_wdata <= w_sel_wdata;
                r_mem_wren  <= w_sel_we & ~w_oor;
            end else begin
                r_mem_wren  <= 1'b0;
            end

            r_pv[0]   <= w_any & ~w_sel_we;
            r_pid[0]  <= w_sel_id;
            r_poor[0] <= w_oor;
            for (int i = 1; i < PIPE_D; i++) begin
                r_pv[i]   <= r_pv[i-1];
                r_pid[i]  <= r_pid[i-1];
                r_poor[i] <= r_poor[i-1];
            end

            if (w_host_win)      r_rr_host <= 1'b0;
            else if (w_zoom_win) r_rr_host <= 1'b1;

            case (r_state)
                ST_ARB: begin
                    if (i_zoom_lock_req) r_state <= ST_FLUSH;
                end
                ST_FLUSH: begin
                    if (!i_zoom_lock_req) begin
                        r_state <= ST_ARB;
                    end else if (!w_host_rd_inflight) begin
                        r_state    <= ST_LOCK;
                        r_lock_ack <= 1'b1;
                    end
                end
                ST_LOCK: begin
                    if (!i_zoom_lock_req) begin
                        r_state    <= ST_ARB;
                        r_lock_ack <= 1'b0;
                    end
                end
                default: begin
                    r_state    <= ST_ARB;
                    r_lock_ack <= 1'b0;
                end
            endcase
        end
    end

    assign o_host_gnt      = w_host_win;
    assign o_zoom_gnt      = w_zoom_win;
    assign o_vga_gnt       = w_vga_win;
    assign o_zoom_lock_ack = r_lock_ack;
    assign o_mem_addr      = r_mem_addr;
    assign o_mem_wdata     = r_mem_wdata;
    assign o_mem_wren      = r_mem_wren;

    assign o_host_rvalid = r_pv[READ_LATENCY] && (r_pid[READ_LATENCY] == ID_HOST);
    assign o_zoom_rvalid = r_pv[READ_LATENCY] && (r_pid[READ_LATENCY] == ID_ZOOM);
    assign o_vga_rvalid  = r_pv[READ_LATENCY] && (r_pid[READ_LATENCY] == ID_VGA);

    // RAM output lines up with the last pipeline stage; out-of-range reads
    // and non-read cycles present zero.
    assign o_rd_data = (r_pv[READ_LATENCY] && !r_poor[READ_LATENCY]) ? i_mem_q : '0;

endmodule

// File: tb/tb_img_mem_arbiter.sv
module tb_img_mem_arbiter;

    localparam int AW    = 16;
    localparam int DW    = 16;
    localparam int DEPTH = 19200;
    localparam int RL    = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          host_req, host_we, host_gnt, host_rvalid;
    logic [AW-1:0] host_addr;
    logic [DW-1:0] host_wdata;
    logic          zoom_req, zoom_we, zoom_gnt, zoom_rvalid;
    logic [AW-1:0] zoom_addr;
    logic [DW-1:0] zoom_wdata;
    logic          lock_req, lock_ack;
    logic          vga_req, vga_gnt, vga_rvalid;
    logic [AW-1:0] vga_addr;
    logic [DW-1:0] rd_data;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_wren;
    logic [DW-1:0] mem_q;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    img_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_DEPTH(DEPTH), .READ_LATENCY(RL)) dut (
        .i_clk(clk), .i_rst(rst),
        .i_host_req(host_req), .i_host_we(host_we), .i_host_addr(host_addr),
        .i_host_wdata(host_wdata), .o_host_gnt(host_gnt), .o_host_rvalid(host_rvalid),
        .i_zoom_req(zoom_req), .i_zoom_we(zoom_we), .i_zoom_addr(zoom_addr),
        .i_zoom_wdata(zoom_wdata), .o_zoom_gnt(zoom_gnt), .o_zoom_rvalid(zoom_rvalid),
        .i_zoom_lock_req(lock_req), .o_zoom_lock_ack(lock_ack),
        .i_vga_req(vga_req), .i_vga_addr(vga_addr), .o_vga_gnt(vga_gnt), .o_vga_rvalid(vga_rvalid),
        .o_rd_data(rd_data), .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata),
        .o_mem_wren(mem_wren), .i_mem_q(mem_q)
    );

    function automatic logic [15:0] init_val(input int a);
        int t;
        t = (a * 499) ^ 50010;
        return t[15:0];
    endfunction

    // RAM model: address registered one clock after mem_addr appears, q
    // registered one clock later. Contents return to a known pattern on reset.
    logic [DW-1:0] ram [0:DEPTH-1];
    logic [AW-1:0] ram_ra;
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) ram[i] <= init_val(i);
        end else if (mem_wren && int'(mem_addr) < DEPTH) begin
            ram[mem_addr] <= mem_wdata;
        end
        ram_ra <= mem_addr;
        mem_q  <= (int'(ram_ra) < DEPTH) ? ram[ram_ra] : 16'hDEAD;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_reqs();
        host_req = 0; host_we = 0; host_addr = '0; host_wdata = '0;
        zoom_req = 0; zoom_we = 0; zoom_addr = '0; zoom_wdata = '0;
        vga_req = 0; vga_addr = '0;
    endtask

    task automatic idle(input int n);
        clr_reqs();
        repeat (n) step();
    endtask

    task automatic test_reset();
        rst = 1; lock_req = 0; clr_reqs();
        step();
        host_req = 1; vga_req = 1;
        @(negedge clk);
        n_chk++;
        if ({host_gnt, zoom_gnt, vga_gnt} !== 3'b000) begin
            n_fail++; $display("FAIL reset_gnt: got %b want 000", {host_gnt, zoom_gnt, vga_gnt});
        end
        n_chk++;
        if ({host_rvalid, zoom_rvalid, vga_rvalid, lock_ack, mem_wren} !== 5'b0) begin
            n_fail++; $display("FAIL reset_flags: got %b want 00000",
                               {host_rvalid, zoom_rvalid, vga_rvalid, lock_ack, mem_wren});
        end
        n_chk++;
        if (mem_addr !== 16'h0 || mem_wdata !== 16'h0 || rd_data !== 16'h0) begin
            n_fail++; $display("FAIL reset_data: addr %h wdata %h rd %h want 0", mem_addr, mem_wdata, rd_data);
        end
        step();
        rst = 0; clr_reqs();
        step();
    endtask

    // Host write then read of the same word; read returns 3 clocks after grant.
    task automatic test_host_rw();
        int lat;
        logic [DW-1:0] rdv;
        logic got;
        host_req = 1; host_we = 1; host_addr = 16'h0010; host_wdata = 16'hABCD;
        @(negedge clk);
        n_chk++;
        if (host_gnt !== 1'b1) begin n_fail++; $display("FAIL t1_wr_gnt: got %b want 1", host_gnt); end
        step();
        host_we = 0;
        @(negedge clk);
        n_chk++;
        if (host_gnt !== 1'b1) begin n_fail++; $display("FAIL t1_rd_gnt: got %b want 1", host_gnt); end
        n_chk++;
        if (mem_wren !== 1'b1 || mem_addr !== 16'h0010 || mem_wdata !== 16'hABCD) begin
            n_fail++; $display("FAIL t1_mem_port: wren %b addr %h data %h want 1 0010 abcd", mem_wren, mem_addr, mem_wdata);
        end
        got = 0; lat = 0; rdv = '0;
        for (int k = 1; k <= 6 && !got; k++) begin
            step();
            host_req = 0;
            @(negedge clk);
            if (host_rvalid === 1'b1) begin got = 1; lat = k; rdv = rd_data; end
        end
        n_chk++;
        if (!got || lat != 3) begin n_fail++; $display("FAIL t1_latency: got %0d (seen %b) want 3", lat, got); end
        n_chk++;
        if (rdv !== 16'hABCD) begin n_fail++; $display("FAIL t1_rdata: got %h want abcd", rdv); end
        idle(4);
    endtask

    task automatic test_round_robin();
        logic [2:0] g, prev;
        prev = 3'b000;
        host_req = 1; host_addr = 16'h0020;
        zoom_req = 1; zoom_addr = 16'h0021;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            g = {host_gnt, zoom_gnt, vga_gnt};
            n_chk++;
            if ((g !== 3'b100 && g !== 3'b010) || (k > 0 && g === prev)) begin
                n_fail++; $display("FAIL t2_alternate: cycle %0d got %b prev %b", k, g, prev);
            end
            prev = g;
            step();
        end
        idle(5);
    endtask

    task automatic test_vga_priority();
        vga_req = 1; vga_addr = 16'h0030;
        host_req = 1; host_addr = 16'h0031;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            n_chk++;
            if (vga_gnt !== 1'b1 || host_gnt !== 1'b0) begin
                n_fail++; $display("FAIL t3_vga_first: vga %b host %b want 1 0", vga_gnt, host_gnt);
            end
            step();
        end
        vga_req = 0;
        @(negedge clk);
        n_chk++;
        if (host_gnt !== 1'b1 || vga_gnt !== 1'b0) begin
            n_fail++; $display("FAIL t3_host_after: host %b vga %b want 1 0", host_gnt, vga_gnt);
        end
        step();
        idle(5);
    endtask

    task automatic test_out_of_range();
        int lat;
        logic got, wren_seen;
        logic [DW-1:0] rdv;
        vga_req = 1; vga_addr = 16'h4B00;
        @(negedge clk);
        n_chk++;
        if (vga_gnt !== 1'b1) begin n_fail++; $display("FAIL t4_vga_gnt: got %b want 1", vga_gnt); end
        got = 0; lat = 0; rdv = '1;
        for (int k = 1; k <= 6 && !got; k++) begin
            step();
            vga_req = 0;
            @(negedge clk);
            if (vga_rvalid === 1'b1) begin got = 1; lat = k; rdv = rd_data; end
        end
        n_chk++;
        if (!got || lat != 3 || rdv !== 16'h0) begin
            n_fail++; $display("FAIL t4_oor_read: lat %0d seen %b data %h want 3 1 0000", lat, got, rdv);
        end
        step();
        host_req = 1; host_we = 1; host_addr = 16'h4B00; host_wdata = 16'hFFFF;
        @(negedge clk);
        n_chk++;
        if (host_gnt !== 1'b1) begin n_fail++; $display("FAIL t4_wr_gnt: got %b want 1", host_gnt); end
        wren_seen = 0;
        for (int k = 0; k < 4; k++) begin
            step();
            host_req = 0;
            @(negedge clk);
            if (mem_wren !== 1'b0) wren_seen = 1;
        end
        n_chk++;
        if (wren_seen) begin n_fail++; $display("FAIL t4_oor_write: mem_wren got 1 want 0"); end
        // Last valid word still writes and reads back.
        step();
        host_req = 1; host_we = 1; host_addr = 16'h4AFF; host_wdata = 16'h1234;
        step();
        host_we = 0;
        step();
        host_req = 0;
        got = 0; rdv = '0;
        for (int k = 0; k < 6 && !got; k++) begin
            @(negedge clk);
            if (host_rvalid === 1'b1) begin got = 1; rdv = rd_data; end
            step();
        end
        n_chk++;
        if (!got || rdv !== 16'h1234) begin
            n_fail++; $display("FAIL t4_last_word: seen %b data %h want 1 1234", got, rdv);
        end
        idle(4);
    endtask

    task automatic test_lock();
        int rv_k, ack_k;
        logic leak;
        logic [DW-1:0] rv_d;
        // Rewrite 0x0010 so the flushed read has a known value.
        host_req = 1; host_we = 1; host_addr = 16'h0010; host_wdata = 16'hABCD;
        step();
        host_we = 0;
        @(negedge clk);
        n_chk++;
        if (host_gnt !== 1'b1) begin n_fail++; $display("FAIL t5_rd_gnt: got %b want 1", host_gnt); end
        step();
        host_req = 0; lock_req = 1;
        step();
        host_req = 1; host_addr = 16'h0012;
        rv_k = -1; ack_k = -1; leak = 0; rv_d = '0;
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            if (host_rvalid === 1'b1) begin rv_k = k; rv_d = rd_data; end
            if (host_gnt !== 1'b0) leak = 1;
            if (lock_ack === 1'b1) begin ack_k = k; break; end
            step();
        end
        n_chk++;
        if (rv_k < 0 || rv_d !== 16'hABCD) begin
            n_fail++; $display("FAIL t5_flush_read: seen %0d data %h want >=0 abcd", rv_k, rv_d);
        end
        n_chk++;
        if (ack_k < 0 || ack_k <= rv_k) begin
            n_fail++; $display("FAIL t5_ack_order: ack at %0d rvalid at %0d want ack later", ack_k, rv_k);
        end
        n_chk++;
        if (leak) begin n_fail++; $display("FAIL t5_host_blocked: host_gnt got 1 want 0"); end
        step();
        zoom_req = 1; zoom_addr = 16'h0013;
        @(negedge clk);
        n_chk++;
        if (zoom_gnt !== 1'b1 || host_gnt !== 1'b0) begin
            n_fail++; $display("FAIL t5_zoom_in_lock: zoom %b host %b want 1 0", zoom_gnt, host_gnt);
        end
        step();
        vga_req = 1; vga_addr = 16'h0014;
        @(negedge clk);
        n_chk++;
        if ({host_gnt, zoom_gnt, vga_gnt} !== 3'b001) begin
            n_fail++; $display("FAIL t5_vga_over_zoom: got %b want 001", {host_gnt, zoom_gnt, vga_gnt});
        end
        step();
        lock_req = 0; zoom_req = 0; vga_req = 0;
        @(negedge clk);
        n_chk++;
        if (lock_ack !== 1'b1 || host_gnt !== 1'b0) begin
            n_fail++; $display("FAIL t5_release_cycle: ack %b host %b want 1 0", lock_ack, host_gnt);
        end
        step();
        @(negedge clk);
        n_chk++;
        if (lock_ack !== 1'b0 || host_gnt !== 1'b1) begin
            n_fail++; $display("FAIL t5_after_release: ack %b host %b want 0 1", lock_ack, host_gnt);
        end
        step();
        idle(5);
    endtask

    task automatic test_reset_inflight();
        logic rv_seen, ack_seen;
        lock_req = 1; vga_req = 1; vga_addr = 16'h0010;
        @(negedge clk);
        n_chk++;
        if (vga_gnt !== 1'b1) begin n_fail++; $display("FAIL t6_rd0_gnt: got %b want 1", vga_gnt); end
        step();
        vga_addr = 16'h0011;
        step();
        rst = 1; lock_req = 0; vga_req = 0;
        @(negedge clk);
        n_chk++;
        if (lock_ack !== 1'b1) begin n_fail++; $display("FAIL t6_locked: ack got %b want 1", lock_ack); end
        step();
        rst = 0;
        @(negedge clk);
        n_chk++;
        if (mem_addr !== 16'h0 || mem_wdata !== 16'h0 || mem_wren !== 1'b0 || rd_data !== 16'h0 ||
            {host_gnt, zoom_gnt, vga_gnt, lock_ack} !== 4'b0) begin
            n_fail++; $display("FAIL t6_reset_vals: addr %h wdata %h wren %b rd %h gnt/ack %b want 0",
                               mem_addr, mem_wdata, mem_wren, rd_data, {host_gnt, zoom_gnt, vga_gnt, lock_ack});
        end
        rv_seen = 0; ack_seen = 0;
        for (int k = 0; k < 6; k++) begin
            if ({host_rvalid, zoom_rvalid, vga_rvalid} !== 3'b000) rv_seen = 1;
            if (lock_ack !== 1'b0) ack_seen = 1;
            step();
            @(negedge clk);
        end
        n_chk++;
        if (rv_seen || ack_seen) begin
            n_fail++; $display("FAIL t6_no_rvalid: rvalid %b ack %b after reset want 0 0", rv_seen, ack_seen);
        end
        step();
    endtask

    typedef struct {
        int            id;     // 0 host, 1 zoom, 2 vga
        logic [15:0]   data;
        int            due;
    } exp_t;

    function automatic logic [15:0] pick_addr();
        if ($urandom_range(0, 7) == 0) return 16'h4B00 + 16'($urandom_range(0, 3));
        return 16'h0100 + 16'($urandom_range(0, 7));
    endfunction

    // Random traffic from all three requesters against a scoreboard: grants
    // follow the priority rules, reads return the latest write in grant order.
    task automatic test_random();
        exp_t q[$];
        exp_t e;
        logic [15:0] refm [0:7];
        logic hp, zp, vp, host_turn;
        logic [2:0] exp_rv, exp_g;
        logic [15:0] exp_d, a, wd;
        logic we;
        int w;
        rst = 1; lock_req = 0; clr_reqs();
        step();
        rst = 0;
        for (int i = 0; i < 8; i++) refm[i] = init_val(256 + i);
        hp = 0; zp = 0; vp = 0; host_turn = 1;
        for (int cyc = 0; cyc < 406; cyc++) begin
            if (cyc < 400) begin
                if (!hp && $urandom_range(0, 2) == 0) begin
                    hp = 1; host_we = 1'($urandom_range(0, 1)); host_addr = pick_addr(); host_wdata = 16'($urandom);
                end
                if (!zp && $urandom_range(0, 2) == 0) begin
                    zp = 1; zoom_we = 1'($urandom_range(0, 1)); zoom_addr = pick_addr(); zoom_wdata = 16'($urandom);
                end
                if (!vp && $urandom_range(0, 3) == 0) begin
                    vp = 1; vga_addr = pick_addr();
                end
            end
            host_req = hp; zoom_req = zp; vga_req = vp;
            @(negedge clk);
            exp_rv = 3'b000; exp_d = '0;
            if (q.size() > 0 && q[0].due == cyc) begin
                e = q.pop_front();
                exp_rv = 3'b100 >> e.id;
                exp_d = e.data;
            end
            n_chk++;
            if ({host_rvalid, zoom_rvalid, vga_rvalid} !== exp_rv ||
                (exp_rv != 3'b000 && rd_data !== exp_d)) begin
                n_fail++; $display("FAIL rand_rdata: cyc %0d rvalid %b data %h want %b %h",
                                   cyc, {host_rvalid, zoom_rvalid, vga_rvalid}, rd_data, exp_rv, exp_d);
            end
            if (vp)                 w = 2;
            else if (hp && zp)      w = host_turn ? 0 : 1;
            else if (hp)            w = 0;
            else if (zp)            w = 1;
            else                    w = -1;
            exp_g = (w < 0) ? 3'b000 : (3'b100 >> w);
            n_chk++;
            if ({host_gnt, zoom_gnt, vga_gnt} !== exp_g) begin
                n_fail++; $display("FAIL rand_gnt: cyc %0d got %b want %b", cyc, {host_gnt, zoom_gnt, vga_gnt}, exp_g);
            end
            if (w >= 0) begin
                if (w == 0)      begin a = host_addr; we = host_we; wd = host_wdata; hp = 0; host_turn = 0; end
                else if (w == 1) begin a = zoom_addr; we = zoom_we; wd = zoom_wdata; zp = 0; host_turn = 1; end
                else             begin a = vga_addr;  we = 0;       wd = '0;         vp = 0; end
                if (we) begin
                    if (int'(a) < DEPTH) refm[a[2:0]] = wd;
                end else begin
                    e.id = w;
                    e.data = (int'(a) < DEPTH) ? refm[a[2:0]] : 16'h0;
                    e.due = cyc + 1 + RL;
                    q.push_back(e);
                end
            end
            step();
        end
        n_chk++;
        if (q.size() != 0) begin n_fail++; $display("FAIL rand_drain: %0d reads outstanding want 0", q.size()); end
        idle(3);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    initial begin
        rst = 1; lock_req = 0; clr_reqs();
        #1;
        test_reset();
        test_host_rw();
        test_round_robin();
        test_vga_priority();
        test_out_of_range();
        test_lock();
        test_reset_inflight();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
